// File: rtl/rx_unit_if.sv
// Configuration, serial input and status outputs of the UART receiver.
interface rx_unit_if;
  logic       data_rx;
  logic [1:0] parity_type;
  logic [1:0] baud_rate;
  logic [7:0] data_out;
  logic       active_flag;
  logic       done_flag;
  logic       parity_error;
  logic       frame_error;

  modport master (
    output data_rx, parity_type, baud_rate,
    input  data_out, active_flag, done_flag, parity_error, frame_error
  );

  modport slave (
    input  data_rx, parity_type, baud_rate,
    output data_out, active_flag, done_flag, parity_error, frame_error
  );
endinterface

// File: rtl/rx_unit.sv
// UART receiver: 16x oversampling, 8-bit LSB-first frames, optional odd/even parity.
// Baud and parity settings are latched at each start edge.
module rx_unit #(
  parameter int unsigned CLK_FREQ_HZ = 100_000_000
) (
  input logic       clock,
  input logic       reset_n,
  rx_unit_if.slave  bus
);
  localparam int unsigned DIV_1200 = CLK_FREQ_HZ / (16 * 1200);
  localparam int unsigned DIV_2400 = CLK_FREQ_HZ / (16 * 2400);
  localparam int unsigned DIV_4800 = CLK_FREQ_HZ / (16 * 4800);
  localparam int unsigned DIV_9600 = CLK_FREQ_HZ / (16 * 9600);
  localparam int unsigned CW       = (DIV_1200 > 1) ? $clog2(DIV_1200) : 1;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  logic          rx_m, rx_s, rx_prev;
  logic          fall;
  logic [2:0]    state;
  logic [1:0]    par_cfg, baud_cfg;
  logic          par_en;
  logic [CW-1:0] div_m1, tick_cnt;
  logic          tick;
  logic [3:0]    samp_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          par_bad;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_m    <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_m    <= bus.data_rx;
      rx_s    <= rx_m;
      rx_prev <= rx_s;
    end
  end

  assign fall   = rx_prev & ~rx_s;
  assign par_en = (par_cfg == 2'b01) || (par_cfg == 2'b10);

  always_comb begin
    div_m1 = CW'(DIV_9600 - 1);
    case (baud_cfg)
      2'b00:   div_m1 = CW'(DIV_1200 - 1);
      2'b01:   div_m1 = CW'(DIV_2400 - 1);
      2'b10:   div_m1 = CW'(DIV_4800 - 1);
      default: div_m1 = CW'(DIV_9600 - 1);
    endcase
  end

  assign tick = (state != IDLE) && (tick_cnt == div_m1);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state            <= IDLE;
      par_cfg          <= '0;
      baud_cfg         <= '0;
      tick_cnt         <= '0;
      samp_cnt         <= '0;
      bit_idx          <= '0;
      shreg            <= '0;
      par_bad          <= 1'b0;
      bus.data_out     <= '0;
      bus.active_flag  <= 1'b0;
      bus.done_flag    <= 1'b0;
      bus.parity_error <= 1'b0;
      bus.frame_error  <= 1'b0;
    end else begin
      bus.done_flag <= 1'b0;
      if (state == IDLE) begin
        tick_cnt <= '0;
        if (fall) begin
          state           <= START;
          samp_cnt        <= '0;
          par_cfg         <= bus.parity_type;
          baud_cfg        <= bus.baud_rate;
          bus.active_flag <= 1'b1;
        end
      end else begin
        if (tick) begin
          tick_cnt <= '0;
          samp_cnt <= samp_cnt + 4'd1;
        end else begin
          tick_cnt <= tick_cnt + 1'b1;
        end
        // START samples on the 8th tick and rebases samp_cnt so every later
        // sample lands on the 16th tick, i.e. mid-bit.
        case (state)
          START: if (tick && samp_cnt == 4'd7) begin
            if (rx_s) begin
              state           <= IDLE;
              bus.active_flag <= 1'b0;
            end else begin
              state    <= DATA;
              samp_cnt <= '0;
              bit_idx  <= '0;
            end
          end
          DATA: if (tick && samp_cnt == 4'd15) begin
            shreg   <= {rx_s, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= par_en ? PARITY : STOP;
          end
          PARITY: if (tick && samp_cnt == 4'd15) begin
            par_bad <= (par_cfg == 2'b01) ? ~(^shreg ^ rx_s) : (^shreg ^ rx_s);
            state   <= STOP;
          end
          STOP: if (tick && samp_cnt == 4'd15) begin
            state            <= IDLE;
            bus.active_flag  <= 1'b0;
            bus.done_flag    <= 1'b1;
            bus.data_out     <= shreg;
            bus.frame_error  <= ~rx_s;
            bus.parity_error <= par_en & par_bad;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
